// File: rtl/snn_delay_layer.sv
// ---------------------------------------------------------------------------
// snn_delay_layer
//
// One layer of N leaky-integrate-and-fire neurons driven by M input spike
// lines. Every synapse (n,m) has its own axonal delay. The delay is served
// from a circular history of the last D = 2^DW input spike vectors. A
// time-step strobe starts a frame. The frame walks the neurons in order,
// accumulates one synapse per clock, then spends one clock on the leak,
// threshold and refractory update. Layers can be cascaded on one shared
// step strobe.
//
// Frame timing: the strobe is accepted on one edge, followed by
// N*(M+1) ACCUM/UPDATE cycles and one FIN cycle. done rises on the FIN
// edge.
//
// Ports:
//   clk                     system clock
//   reset                   synchronous, active-high reset
//   enable                  gates frame start only
//   step_tick               one-cycle time-step strobe
//   input_spikes[M]         spikes of the current time step
//   weights[N*M*WW]         signed weight (n,m) at [(n*M+m)*WW +: WW]
//   delay_values[N*M*DW]    delay (n,m) at [(n*M+m)*DW +: DW]
//   delays[N*M]             per-synapse delay enable (0 = current step)
//   threshold[8]            firing threshold (unsigned)
//   decay[8]                leak subtracted per step (unsigned)
//   refractory_period[8]    refractory length in steps
//   membrane_potential_out  potential of neuron n at [n*8 +: 8]
//   output_spikes[N]        spikes of the last completed step
//   busy                    frame in progress
//   done                    one-cycle pulse at frame completion
//   overrun                 (STEP_OVERRUN_EN only) sticky flag: a tick
//                           arrived while busy; cleared only by reset
//
// Optional feature macro: STEP_OVERRUN_EN
// ---------------------------------------------------------------------------
module snn_delay_layer #(
  parameter int M  = 20,
  parameter int N  = 8,
  parameter int DW = 3,
  parameter int WW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  step_tick,
  input  logic [M-1:0]          input_spikes,
  input  logic [N*M*WW-1:0]     weights,
  input  logic [N*M*DW-1:0]     delay_values,
  input  logic [N*M-1:0]        delays,
  input  logic [7:0]            threshold,
  input  logic [7:0]            decay,
  input  logic [7:0]            refractory_period,
  output logic [N*8-1:0]        membrane_potential_out,
  output logic [N-1:0]          output_spikes,
  output logic                  busy,
`ifdef STEP_OVERRUN_EN
  output logic                  done,
  output logic                  overrun
`else
  output logic                  done
`endif
);

  localparam int D     = 1 << DW;
  localparam int ACC_W = WW + $clog2(M) + 1;
  localparam int MW    = (M > 1) ? $clog2(M) : 1;
  localparam int NW    = (N > 1) ? $clog2(N) : 1;
  localparam int IW    = $clog2(N * M);
  // Width of the leak+input sum: it must hold 0..255 plus any accumulator value
  localparam int TW    = ((ACC_W > 9) ? ACC_W : 9) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2,
    FIN    = 2'd3
  } state_t;

  // Sign-extend one synaptic weight to the accumulator width
  function automatic logic signed [ACC_W-1:0] sext_w(input logic signed [WW-1:0] w);
    return {{(ACC_W-WW){w[WW-1]}}, w};
  endfunction

  // Clamp a signed sum to the unsigned 8-bit potential range
  function automatic logic [7:0] sat_u8(input logic signed [TW-1:0] t);
    if (t < 0)
      return 8'd0;
    else if (t > $signed(TW'(255)))
      return 8'd255;
    else
      return t[7:0];
  endfunction

  state_t                   state_q;
  logic [NW-1:0]            n_q;
  logic [MW-1:0]            m_q;
  logic [DW-1:0]            wr_ptr_q;
  logic [M-1:0]             hist_q [D];
  logic signed [ACC_W-1:0]  acc_q;
  logic [7:0]               v_q    [N];
  logic [7:0]               refr_q [N];
  logic [N-1:0]             spk_stage_q;
  logic [N-1:0]             out_spk_q;
  logic                     busy_q;
  logic                     done_q;
`ifdef STEP_OVERRUN_EN
  logic                     overrun_q;
`endif

  // Synapse fetch for the current (n,m): delayed history bit and weight
  logic [IW-1:0]            syn_idx;
  logic [DW-1:0]            dly;
  logic [DW-1:0]            slot;
  logic                     hist_bit;
  logic signed [WW-1:0]     w_cur;
  logic signed [ACC_W-1:0]  acc_d;

  always_comb begin
    syn_idx  = IW'(n_q) * IW'(M) + IW'(m_q);
    dly      = delays[syn_idx] ? delay_values[syn_idx*DW +: DW] : '0;
    // wr_ptr_q already points past the newest step, so d=0 is wr_ptr_q-1
    slot     = wr_ptr_q - DW'(1) - dly;
    hist_bit = hist_q[slot][m_q];
    w_cur    = weights[syn_idx*WW +: WW];
    acc_d    = hist_bit ? (acc_q + sext_w(w_cur)) : acc_q;
  end

  // Neuron update for neuron n_q: leak with floor at 0, add input, clamp
  logic [7:0]               v_cur;
  logic [7:0]               refr_cur;
  logic [7:0]               v_leak;
  logic signed [TW-1:0]     t_full;
  logic [7:0]               t_sat;
  logic                     fire;

  always_comb begin
    v_cur    = v_q[n_q];
    refr_cur = refr_q[n_q];
    v_leak   = (v_cur > decay) ? (v_cur - decay) : 8'd0;
    t_full   = $signed({{(TW-8){1'b0}}, v_leak})
             + $signed({{(TW-ACC_W){acc_q[ACC_W-1]}}, acc_q});
    t_sat    = sat_u8(t_full);
    fire     = (t_sat >= threshold);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      m_q         <= '0;
      wr_ptr_q    <= '0;
      acc_q       <= '0;
      spk_stage_q <= '0;
      out_spk_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < D; i++) hist_q[i] <= '0;
      for (int i = 0; i < N; i++) begin
        v_q[i]    <= '0;
        refr_q[i] <= '0;
      end
`ifdef STEP_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef STEP_OVERRUN_EN
      if (step_tick && busy_q) overrun_q <= 1'b1;
`endif
      case (state_q)
        IDLE: begin
          // Ticks are only accepted here, so a tick while busy never
          // touches the history buffer
          if (step_tick && enable) begin
            hist_q[wr_ptr_q] <= input_spikes;
            wr_ptr_q         <= wr_ptr_q + DW'(1);
            n_q              <= '0;
            m_q              <= '0;
            acc_q            <= '0;
            busy_q           <= 1'b1;
            state_q          <= ACCUM;
          end
        end

        ACCUM: begin
          acc_q <= acc_d;
          if (m_q == MW'(M - 1)) begin
            m_q     <= '0;
            state_q <= UPDATE;
          end else begin
            m_q <= m_q + MW'(1);
          end
        end

        UPDATE: begin
          if (refr_cur != 8'd0) begin
            refr_q[n_q]      <= refr_cur - 8'd1;
            v_q[n_q]         <= 8'd0;
            spk_stage_q[n_q] <= 1'b0;
          end else if (fire) begin
            refr_q[n_q]      <= refractory_period;
            v_q[n_q]         <= 8'd0;
            spk_stage_q[n_q] <= 1'b1;
          end else begin
            v_q[n_q]         <= t_sat;
            spk_stage_q[n_q] <= 1'b0;
          end
          acc_q <= '0;
          if (n_q == NW'(N - 1)) begin
            state_q <= FIN;
          end else begin
            n_q     <= n_q + NW'(1);
            state_q <= ACCUM;
          end
        end

        FIN: begin
          out_spk_q <= spk_stage_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_vout
    assign membrane_potential_out[g*8 +: 8] = v_q[g];
  end

  assign output_spikes = out_spk_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef STEP_OVERRUN_EN
  assign overrun       = overrun_q;
`endif

endmodule

// File: tb/tb_snn_delay_layer.sv
// ---------------------------------------------------------------------------
// tb_snn_delay_layer
//
// Directed bench for snn_delay_layer with M=4, N=2, DW=3, WW=8. Each time
// step pushes its hand-derived expected result (output spikes and both
// membrane potentials) onto a scoreboard queue. The entry is popped and
// compared when the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_snn_delay_layer;

  localparam int M  = 4;
  localparam int N  = 2;
  localparam int DW = 3;
  localparam int WW = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               step_tick = 1'b0;
  logic [M-1:0]       input_spikes = '0;
  logic [N*M*WW-1:0]  weights = '0;
  logic [N*M*DW-1:0]  delay_values = '0;
  logic [N*M-1:0]     delays = '0;
  logic [7:0]         threshold = 8'd20;
  logic [7:0]         decay = 8'd0;
  logic [7:0]         refractory_period = 8'd0;
  logic [N*8-1:0]     membrane_potential_out;
  logic [N-1:0]       output_spikes;
  logic               busy;
  logic               done;
`ifdef STEP_OVERRUN_EN
  logic               overrun;
`endif

  snn_delay_layer #(.M(M), .N(N), .DW(DW), .WW(WW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable                 (enable),
    .step_tick              (step_tick),
    .input_spikes           (input_spikes),
    .weights                (weights),
    .delay_values           (delay_values),
    .delays                 (delays),
    .threshold              (threshold),
    .decay                  (decay),
    .refractory_period      (refractory_period),
    .membrane_potential_out (membrane_potential_out),
    .output_spikes          (output_spikes),
    .busy                   (busy),
`ifdef STEP_OVERRUN_EN
    .done                   (done),
    .overrun                (overrun)
`else
    .done                   (done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] spk;
    logic [7:0] v0;
    logic [7:0] v1;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    step_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_cfg();
    weights = '0;
    delays = '0;
    delay_values = '0;
    threshold = 8'd20;
    decay = 8'd0;
    refractory_period = 8'd0;
  endtask

  task automatic set_w(input int n, input int m, input int val);
    weights[(n*M+m)*WW +: WW] = WW'(val);
  endtask

  // One time step: push expectation, strobe, wait (bounded) for done,
  // then pop and compare. ovr_at > 0 fires an extra tick that many
  // cycles into the frame, which must be ignored.
  task automatic run_step(input string tag, input logic [M-1:0] sp,
                          input logic [1:0] e_spk, input logic [7:0] e_v0,
                          input logic [7:0] e_v1, input int ovr_at,
                          input logic [M-1:0] ovr_sp);
    exp_t e;
    exp_t got;
    int cyc;
    e.spk = e_spk;
    e.v0  = e_v0;
    e.v1  = e_v1;
    sb.push_back(e);
    @(negedge clk);
    input_spikes = sp;
    enable = 1'b1;
    step_tick = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      step_tick = 1'b0;
      if (cyc == 1) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        // Dropping enable mid-frame must not stop the frame
        if (ovr_at == 0) enable = 1'b0;
      end
      if (ovr_at != 0 && cyc == ovr_at) begin
        input_spikes = ovr_sp;
        step_tick = 1'b1;
      end
      if (done) break;
    end
    step_tick = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'd12);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    got.spk = output_spikes;
    got.v0  = membrane_potential_out[7:0];
    got.v1  = membrane_potential_out[15:8];
    e = sb.pop_front();
    chk({tag, "_spk"}, 32'(got.spk), 32'(e.spk));
    chk({tag, "_v0"}, 32'(got.v0), 32'(e.v0));
    chk({tag, "_v1"}, 32'(got.v1), 32'(e.v1));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    // Reset state
    clear_cfg();
    do_reset();
    #1;
    chk("rst_vout", 32'(membrane_potential_out), 32'd0);
    chk("rst_spk", 32'(output_spikes), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef STEP_OVERRUN_EN
    chk("rst_overrun", 32'(overrun), 32'd0);
`endif

    // Integration: 10 per step, fires at 20
    set_w(0, 0, 10);
    run_step("int1", 4'b0001, 2'b00, 8'd10, 8'd0, 0, '0);
    run_step("int2", 4'b0001, 2'b01, 8'd0, 8'd0, 0, '0);
    run_step("int3", 4'b0001, 2'b00, 8'd10, 8'd0, 0, '0);

    // Reset in the middle of a frame
    @(negedge clk);
    input_spikes = 4'b0001;
    enable = 1'b1;
    step_tick = 1'b1;
    @(negedge clk);
    step_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_vout", 32'(membrane_potential_out), 32'd0);
    chk("midrst_spk", 32'(output_spikes), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 32'(done), 32'd0);
    run_step("midrst_clean", 4'b0001, 2'b00, 8'd10, 8'd0, 0, '0);

    // Delay of 3 steps
    do_reset();
    clear_cfg();
    set_w(0, 0, 30);
    delays[0] = 1'b1;
    delay_values[2:0] = 3'd3;
    run_step("dly3_s0", 4'b0001, 2'b00, 8'd0, 8'd0, 0, '0);
    for (int k = 1; k <= 4; k++)
      run_step($sformatf("dly3_s%0d", k), 4'b0000, (k == 3) ? 2'b01 : 2'b00,
               8'd0, 8'd0, 0, '0);

    // Delay of D-1: oldest stored step, then overwritten
    do_reset();
    delay_values[2:0] = 3'd7;
    run_step("dly7_s0", 4'b0001, 2'b00, 8'd0, 8'd0, 0, '0);
    for (int k = 1; k <= 8; k++)
      run_step($sformatf("dly7_s%0d", k), 4'b0000, (k == 7) ? 2'b01 : 2'b00,
               8'd0, 8'd0, 0, '0);

    // Refractory period of 2
    do_reset();
    clear_cfg();
    set_w(0, 0, 30);
    refractory_period = 8'd2;
    for (int k = 0; k < 6; k++)
      run_step($sformatf("refr_s%0d", k), 4'b0001, (k % 3 == 0) ? 2'b01 : 2'b00,
               8'd0, 8'd0, 0, '0);

    // Arithmetic: floor at 0, clamp at 255, threshold 0
    do_reset();
    clear_cfg();
    threshold = 8'd255;
    set_w(0, 0, 10);
    run_step("ar_load", 4'b0001, 2'b00, 8'd10, 8'd0, 0, '0);
    decay = 8'd5;
    set_w(0, 0, -50);
    run_step("ar_floor", 4'b0001, 2'b00, 8'd0, 8'd0, 0, '0);
    decay = 8'd0;
    for (int m = 0; m < M; m++) set_w(0, m, 127);
    set_w(1, 0, 127);
    set_w(1, 1, 127);
    run_step("ar_clamp", 4'b1111, 2'b01, 8'd0, 8'd254, 0, '0);
    threshold = 8'd0;
    run_step("ar_thr0", 4'b0000, 2'b11, 8'd0, 8'd0, 0, '0);

    // Tick while busy: ignored, history untouched
    do_reset();
    clear_cfg();
    set_w(0, 0, 30);
    delays[0] = 1'b1;
    delay_values[2:0] = 3'd1;
    run_step("ovr_a", 4'b0000, 2'b00, 8'd0, 8'd0, 3, 4'b0001);
    run_step("ovr_b", 4'b0000, 2'b00, 8'd0, 8'd0, 0, '0);
`ifdef STEP_OVERRUN_EN
    chk("ovr_flag", 32'(overrun), 32'd1);
    run_step("ovr_c", 4'b0000, 2'b00, 8'd0, 8'd0, 0, '0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    do_reset();
    #1;
    chk("ovr_cleared", 32'(overrun), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
